adder_tree_arbiter: RTL and testbench

- Shares one pipelined N-ary adder tree between NUM_REQ requesters.
- Each requester streams vectors of NUM_ELEMENTS terms as sop/eop packets.
- The arbiter grants one packet at a time, round-robin, packet-atomic. It tags the tree-side ctl with the requester ID and routes each reduced sum back to the owner.
- Sits between the per-requester MSM/NTT accumulation front-ends and the shared tree instance.

---
 rtl/adder_tree_arbiter.sv | 166 ++++++++++++++++
 tb/tb_adder_tree_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_arbiter.sv
// adder_tree_arbiter
//
// Lets NUM_REQ requesters share one pipelined adder tree. One packet is granted
// at a time and is never interleaved with another. Each beat sent to the tree is
// tagged with the owner's ID in the MSBs of the ctl field. The tree returns the
// tag unchanged, and that tag routes each reduced sum back to its owner with no
// buffering on the return path.
//
// Build option:
//   ADDER_TREE_ARB_FIXED_PRIO_EN  defined   -> fixed priority (lowest index wins, no ptr)
//                                 undefined -> round-robin (default)
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_*             per-requester term vectors, user ctl and stream flags
//   o_req_rdy           per-requester ready (only the granted bit can be high)
//   o_tree_*            beat to the tree, ctl = {id, user ctl}
//   i_tree_rdy          tree input ready
//   i_tree_*            tree result: sum, tagged ctl and flags
//   o_tree_rdy          result ready back to the tree (from the owner's rsp ready)
//   o_rsp_s/ctl/sop/eop shared result bus, tag stripped from ctl
//   o_rsp_val           one-hot result valid, indexed by the returned tag
//   i_rsp_rdy           per-requester result ready
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; choose the next requester from the pending valids
// BUSY  | requester gnt owns the tree until its eop beat handshakes
module adder_tree_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_ELEMENTS = 4,
  parameter int BIT_LEN      = 16,
  parameter int CTL_BITS     = 8,
  parameter int ID_BITS      = $clog2(NUM_REQ)
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst,
  input  logic [NUM_REQ-1:0][NUM_ELEMENTS-1:0][BIT_LEN-1:0] i_req_terms,
  input  logic [NUM_REQ-1:0][CTL_BITS-1:0]               i_req_ctl,
  input  logic [NUM_REQ-1:0]                             i_req_val,
  input  logic [NUM_REQ-1:0]                             i_req_sop,
  input  logic [NUM_REQ-1:0]                             i_req_eop,
  output logic [NUM_REQ-1:0]                             o_req_rdy,
  output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]           o_tree_terms,
  output logic [CTL_BITS+ID_BITS-1:0]                    o_tree_ctl,
  output logic                                           o_tree_val,
  output logic                                           o_tree_sop,
  output logic                                           o_tree_eop,
  input  logic                                           i_tree_rdy,
  input  logic [BIT_LEN-1:0]                             i_tree_s,
  input  logic [CTL_BITS+ID_BITS-1:0]                    i_tree_ctl,
  input  logic                                           i_tree_val,
  input  logic                                           i_tree_sop,
  input  logic                                           i_tree_eop,
  output logic                                           o_tree_rdy,
  output logic [BIT_LEN-1:0]                             o_rsp_s,
  output logic [CTL_BITS-1:0]                            o_rsp_ctl,
  output logic                                           o_rsp_sop,
  output logic                                           o_rsp_eop,
  output logic [NUM_REQ-1:0]                             o_rsp_val,
  input  logic [NUM_REQ-1:0]                             i_rsp_rdy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q;
  logic [ID_BITS-1:0]   gnt_q;
  logic [ID_BITS-1:0]   search_base;
  logic [ID_BITS-1:0]   pick;
  logic [ID_BITS-1:0]   cand;
  logic                 beat_hs;
  logic                 last_hs;
  logic [ID_BITS-1:0]   rsp_id;

`ifdef ADDER_TREE_ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  logic [ID_BITS-1:0]   ptr_q;
  logic [ID_BITS-1:0]   gnt_inc;

  // Explicit wrap so non-power-of-2 NUM_REQ never points past the last requester.
  assign gnt_inc     = (gnt_q == ID_BITS'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
  assign search_base = ptr_q;
`endif

  // Walk from the highest offset down so the candidate nearest search_base
  // is the last one written and wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ID_BITS'((int'(search_base) + i) % NUM_REQ);
      if (i_req_val[cand]) pick = cand;
    end
  end

  // Forward path: a pure mux from the granted requester while BUSY.
  always_comb begin
    o_tree_terms = '0;
    o_tree_ctl   = '0;
    o_tree_val   = 1'b0;
    o_tree_sop   = 1'b0;
    o_tree_eop   = 1'b0;
    o_req_rdy    = '0;
    if (state_q == BUSY) begin
      o_tree_terms     = i_req_terms[gnt_q];
      o_tree_ctl       = {gnt_q, i_req_ctl[gnt_q]};
      o_tree_val       = i_req_val[gnt_q];
      o_tree_sop       = i_req_sop[gnt_q];
      o_tree_eop       = i_req_eop[gnt_q];
      o_req_rdy[gnt_q] = i_tree_rdy;
    end
  end

  assign beat_hs = o_tree_val & i_tree_rdy;
  assign last_hs = beat_hs & o_tree_eop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
`ifndef ADDER_TREE_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|i_req_val) begin
            gnt_q   <= pick;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (last_hs) begin
            state_q <= IDLE;
`ifndef ADDER_TREE_ARB_FIXED_PRIO_EN
            ptr_q   <= gnt_inc;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Return path: the tag in the ctl MSBs selects the owner. A tag outside the
  // requester range has no owner, so the beat is accepted and dropped.
  assign rsp_id    = i_tree_ctl[CTL_BITS +: ID_BITS];
  assign o_rsp_s   = i_tree_s;
  assign o_rsp_ctl = i_tree_ctl[CTL_BITS-1:0];
  assign o_rsp_sop = i_tree_sop;
  assign o_rsp_eop = i_tree_eop;

  always_comb begin
    o_rsp_val  = '0;
    o_tree_rdy = 1'b1;
    if (int'(rsp_id) < NUM_REQ) begin
      o_rsp_val[rsp_id] = i_tree_val;
      o_tree_rdy        = i_rsp_rdy[rsp_id];
    end
  end

endmodule

// File: tb/tb_adder_tree_arbiter.sv
`timescale 1ns/1ps
module tb_adder_tree_arbiter;
  localparam int NR = 4, NE = 4, BL = 16, CB = 8, IB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic [NR-1:0][NE-1:0][BL-1:0] req_terms;
  logic [NR-1:0][CB-1:0]       req_ctl;
  logic [NR-1:0]               req_val, req_sop, req_eop, o_req_rdy;
  logic [NE-1:0][BL-1:0]       o_tree_terms;
  logic [CB+IB-1:0]            o_tree_ctl;
  logic                        o_tree_val, o_tree_sop, o_tree_eop;
  logic                        tree_rdy;
  logic [BL-1:0]               tree_s;
  logic [CB+IB-1:0]            tree_ctl;
  logic                        tree_val, tree_sop, tree_eop;
  logic                        o_tree_rdy;
  logic [BL-1:0]               o_rsp_s;
  logic [CB-1:0]               o_rsp_ctl;
  logic                        o_rsp_sop, o_rsp_eop;
  logic [NR-1:0]               o_rsp_val, rsp_rdy;

  adder_tree_arbiter #(.NUM_REQ(NR), .NUM_ELEMENTS(NE), .BIT_LEN(BL), .CTL_BITS(CB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_terms(req_terms), .i_req_ctl(req_ctl),
    .i_req_val(req_val), .i_req_sop(req_sop), .i_req_eop(req_eop),
    .o_req_rdy(o_req_rdy),
    .o_tree_terms(o_tree_terms), .o_tree_ctl(o_tree_ctl),
    .o_tree_val(o_tree_val), .o_tree_sop(o_tree_sop), .o_tree_eop(o_tree_eop),
    .i_tree_rdy(tree_rdy),
    .i_tree_s(tree_s), .i_tree_ctl(tree_ctl),
    .i_tree_val(tree_val), .i_tree_sop(tree_sop), .i_tree_eop(tree_eop),
    .o_tree_rdy(o_tree_rdy),
    .o_rsp_s(o_rsp_s), .o_rsp_ctl(o_rsp_ctl),
    .o_rsp_sop(o_rsp_sop), .o_rsp_eop(o_rsp_eop),
    .o_rsp_val(o_rsp_val), .i_rsp_rdy(rsp_rdy)
  );

  typedef struct { logic [NE*BL-1:0] terms; logic [CB-1:0] ctl; logic sop; logic eop; int pre; } beat_t;
  typedef struct { logic [NE*BL-1:0] terms; logic [CB+IB-1:0] ctl; logic sop; logic eop; int at; } texp_t;
  typedef struct { logic [BL-1:0] s; logic [CB+IB-1:0] ctl; logic sop; logic eop; } tout_t;
  typedef struct { logic [NR-1:0] val; logic [BL-1:0] s; logic [CB-1:0] ctl; logic sop; logic eop; } rexp_t;

  beat_t req_q [NR][$];
  tout_t tout_q [$];
  texp_t exp_tree [$];
  rexp_t exp_rsp [$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int rsp_hs3 = 0;
  int pre_cnt [NR];
  logic [NR-1:0] hs_req;
  logic hs_tout;
  int ord [6] = '{0, 1, 2, 3, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_beat(input int r, input logic [63:0] t, input logic [7:0] c,
                           input logic s, input logic e, input int pre);
    beat_t b;
    b.terms = t; b.ctl = c; b.sop = s; b.eop = e; b.pre = pre;
    req_q[r].push_back(b);
  endtask

  task automatic exp_beat(input int r, input logic [63:0] t, input logic [7:0] c,
                          input logic s, input logic e, input int at);
    texp_t x;
    x.terms = t; x.ctl = {IB'(r), c}; x.sop = s; x.eop = e; x.at = at;
    exp_tree.push_back(x);
  endtask

  task automatic push_tout(input int id, input logic [15:0] s, input logic [7:0] c,
                           input logic so, input logic eo);
    tout_t o;
    rexp_t x;
    o.s = s; o.ctl = {IB'(id), c}; o.sop = so; o.eop = eo;
    tout_q.push_back(o);
    x.val = NR'(1) << id; x.s = s; x.ctl = c; x.sop = so; x.eop = eo;
    exp_rsp.push_back(x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int r = 0; r < NR; r++) req_q[r].delete();
    tout_q.delete();
    exp_tree.delete();
    exp_rsp.delete();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_drain(input string nm, input int max);
    int n = 0;
    int left;
    left = exp_tree.size() + exp_rsp.size() + tout_q.size();
    for (int r = 0; r < NR; r++) left += req_q[r].size();
    while (left != 0 && n < max) begin
      step();
      n++;
      left = exp_tree.size() + exp_rsp.size() + tout_q.size();
      for (int r = 0; r < NR; r++) left += req_q[r].size();
    end
    chk({nm, "_drain_left"}, 64'(left), 64'd0);
  endtask

  // Requester and tree-output sources: sample handshakes at negedge, advance after posedge.
  initial begin
    req_terms = '0; req_ctl = '0; req_val = '0; req_sop = '0; req_eop = '0;
    tree_s = '0; tree_ctl = '0; tree_val = 1'b0; tree_sop = 1'b0; tree_eop = 1'b0;
    hs_req = '0; hs_tout = 1'b0;
    for (int r = 0; r < NR; r++) pre_cnt[r] = 0;
    forever begin
      @(negedge clk);
      hs_req  = req_val & o_req_rdy;
      hs_tout = tree_val & o_tree_rdy;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (hs_req[r] && req_q[r].size() > 0) begin
          void'(req_q[r].pop_front());
          pre_cnt[r] = 0;
        end
        if (req_q[r].size() == 0) begin
          req_val[r] = 1'b0;
          pre_cnt[r] = 0;
        end else if (pre_cnt[r] < req_q[r][0].pre) begin
          req_val[r] = 1'b0;
          pre_cnt[r]++;
        end else begin
          req_val[r]   = 1'b1;
          req_terms[r] = req_q[r][0].terms;
          req_ctl[r]   = req_q[r][0].ctl;
          req_sop[r]   = req_q[r][0].sop;
          req_eop[r]   = req_q[r][0].eop;
        end
      end
      if (hs_tout && tout_q.size() > 0) void'(tout_q.pop_front());
      if (tout_q.size() == 0) begin
        tree_val = 1'b0;
      end else begin
        tree_val = 1'b1;
        tree_s   = tout_q[0].s;
        tree_ctl = tout_q[0].ctl;
        tree_sop = tout_q[0].sop;
        tree_eop = tout_q[0].eop;
      end
    end
  end

  // Monitor: pops expected beats on every handshake at either side of the arbiter.
  initial begin
    texp_t te;
    rexp_t re;
    forever begin
      @(negedge clk);
      if (o_tree_val && tree_rdy) begin
        if (exp_tree.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL tree_unexpected: got beat ctl %0h expected none (cycle %0d)", o_tree_ctl, cyc);
        end else begin
          te = exp_tree.pop_front();
          chk("tree_terms", 64'(o_tree_terms), 64'(te.terms));
          chk("tree_ctl", 64'(o_tree_ctl), 64'(te.ctl));
          chk("tree_sop", 64'(o_tree_sop), 64'(te.sop));
          chk("tree_eop", 64'(o_tree_eop), 64'(te.eop));
          if (te.at >= 0) chk("tree_cycle", 64'(cyc), 64'(te.at));
        end
      end
      if ((o_rsp_val & rsp_rdy) != '0) begin
        if (o_rsp_val[3] && rsp_rdy[3]) rsp_hs3++;
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rsp_unexpected: got val %0h expected none (cycle %0d)", o_rsp_val, cyc);
        end else begin
          re = exp_rsp.pop_front();
          chk("rsp_val", 64'(o_rsp_val), 64'(re.val));
          chk("rsp_s", 64'(o_rsp_s), 64'(re.s));
          chk("rsp_ctl", 64'(o_rsp_ctl), 64'(re.ctl));
          chk("rsp_sop", 64'(o_rsp_sop), 64'(re.sop));
          chk("rsp_eop", 64'(o_rsp_eop), 64'(re.eop));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, hs_before, guard;
    rst = 1'b1;
    tree_rdy = 1'b1;
    rsp_rdy = '1;

    // Reset state
    do_reset();
    chk("rst_req_rdy", 64'(o_req_rdy), 64'd0);
    chk("rst_tree_val", 64'(o_tree_val), 64'd0);
    chk("rst_tree_terms", 64'(o_tree_terms), 64'd0);
    chk("rst_tree_ctl", 64'(o_tree_ctl), 64'd0);
    chk("rst_rsp_val", 64'(o_rsp_val), 64'd0);

    // Req 0 alone, 3-beat packet; tree returns 10, 20, 1
    k = cyc;
    push_beat(0, pack4(1, 2, 3, 4), 8'h11, 1'b1, 1'b0, 0);
    push_beat(0, pack4(5, 5, 5, 5), 8'h12, 1'b0, 1'b0, 0);
    push_beat(0, pack4(0, 0, 0, 1), 8'h13, 1'b0, 1'b1, 0);
    exp_beat(0, pack4(1, 2, 3, 4), 8'h11, 1'b1, 1'b0, k + 2);
    exp_beat(0, pack4(5, 5, 5, 5), 8'h12, 1'b0, 1'b0, k + 3);
    exp_beat(0, pack4(0, 0, 0, 1), 8'h13, 1'b0, 1'b1, k + 4);
    push_tout(0, 16'd10, 8'h11, 1'b1, 1'b0);
    push_tout(0, 16'd20, 8'h11, 1'b0, 1'b0);
    push_tout(0, 16'd1,  8'h11, 1'b0, 1'b1);
    wait_drain("single_req", 40);

    // All four requesters, single-beat packets: rotation 0,1,2,3,0,1 with one bubble each
    do_reset();
    k = cyc;
    for (int r = 0; r < NR; r++) push_beat(r, pack4(16'(16 * r), 1, 2, 3), 8'h20 + 8'(r), 1'b1, 1'b1, 0);
    push_beat(0, pack4(16'h100, 1, 2, 3), 8'h20, 1'b1, 1'b1, 0);
    push_beat(1, pack4(16'h110, 1, 2, 3), 8'h21, 1'b1, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      exp_beat(ord[i], pack4(16'((i / 4) * 16'h100 + 16 * ord[i]), 1, 2, 3), 8'h20 + 8'(ord[i]),
               1'b1, 1'b1, k + 2 + 2 * i);
      push_tout(ord[i], 16'h100 + 16'(i), 8'h20 + 8'(ord[i]), 1'b1, 1'b1);
    end
    wait_drain("rotation", 60);

    // Req 1 4-beat packet with a val gap on beat 3; req 2 raises val mid-packet
    do_reset();
    k = cyc;
    push_beat(1, pack4(1, 1, 1, 1), 8'h31, 1'b1, 1'b0, 0);
    push_beat(1, pack4(2, 2, 2, 2), 8'h31, 1'b0, 1'b0, 0);
    push_beat(1, pack4(3, 3, 3, 3), 8'h31, 1'b0, 1'b0, 2);
    push_beat(1, pack4(4, 4, 4, 4), 8'h31, 1'b0, 1'b1, 0);
    push_beat(2, pack4(7, 7, 7, 7), 8'h32, 1'b1, 1'b0, 3);
    push_beat(2, pack4(8, 8, 8, 8), 8'h32, 1'b0, 1'b1, 0);
    exp_beat(1, pack4(1, 1, 1, 1), 8'h31, 1'b1, 1'b0, k + 2);
    exp_beat(1, pack4(2, 2, 2, 2), 8'h31, 1'b0, 1'b0, k + 3);
    exp_beat(1, pack4(3, 3, 3, 3), 8'h31, 1'b0, 1'b0, k + 6);
    exp_beat(1, pack4(4, 4, 4, 4), 8'h31, 1'b0, 1'b1, k + 7);
    exp_beat(2, pack4(7, 7, 7, 7), 8'h32, 1'b1, 1'b0, k + 9);
    exp_beat(2, pack4(8, 8, 8, 8), 8'h32, 1'b0, 1'b1, k + 10);
    wait_drain("no_interleave", 40);

    // Tree input stall for 5 cycles on beat 2 of a req 3 packet
    do_reset();
    k = cyc;
    push_beat(3, pack4(9, 8, 7, 6), 8'h41, 1'b1, 1'b0, 0);
    push_beat(3, pack4(5, 4, 3, 2), 8'h42, 1'b0, 1'b0, 0);
    push_beat(3, pack4(1, 0, 1, 0), 8'h43, 1'b0, 1'b1, 0);
    exp_beat(3, pack4(9, 8, 7, 6), 8'h41, 1'b1, 1'b0, k + 2);
    exp_beat(3, pack4(5, 4, 3, 2), 8'h42, 1'b0, 1'b0, k + 8);
    exp_beat(3, pack4(1, 0, 1, 0), 8'h43, 1'b0, 1'b1, k + 9);
    step(); step(); step();
    chk("stall_pre_req_rdy", 64'(o_req_rdy), 64'h8);
    tree_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_req_rdy", 64'(o_req_rdy), 64'd0);
      chk("stall_tree_val", 64'(o_tree_val), 64'd1);
      chk("stall_tree_terms", 64'(o_tree_terms), pack4(5, 4, 3, 2));
      step();
    end
    tree_rdy = 1'b1;
    wait_drain("tree_stall", 30);

    // Return stall: tag 3 held until requester 3 is ready, then one handshake
    do_reset();
    rsp_rdy = 4'b0111;
    push_tout(3, 16'h1234, 8'h5A, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("ret_stall_tree_rdy", 64'(o_tree_rdy), 64'd0);
      chk("ret_stall_rsp_val", 64'(o_rsp_val), 64'h8);
      step();
    end
    hs_before = rsp_hs3;
    rsp_rdy = 4'hF;
    for (int i = 0; i < 4; i++) step();
    chk("ret_stall_hs_count", 64'(rsp_hs3 - hs_before), 64'd1);
    wait_drain("ret_stall", 10);

    // Reset during req 2's packet: ptr must come back to 0
    do_reset();
    k = cyc;
    push_beat(1, pack4(6, 6, 6, 6), 8'h61, 1'b1, 1'b1, 0);
    for (int b = 0; b < 4; b++)
      push_beat(2, pack4(16'(b), 16'(b), 16'(b), 16'(b)), 8'h62, b == 0, b == 3, 0);
    exp_beat(1, pack4(6, 6, 6, 6), 8'h61, 1'b1, 1'b1, k + 2);
    exp_beat(2, pack4(0, 0, 0, 0), 8'h62, 1'b1, 1'b0, k + 4);
    exp_beat(2, pack4(1, 1, 1, 1), 8'h62, 1'b0, 1'b0, k + 5);
    guard = 0;
    while (exp_tree.size() > 1 && guard < 20) begin
      step();
      guard++;
    end
    chk("rst_mid_reach_beat2", 64'(exp_tree.size()), 64'd1);
    rst = 1'b1;
    step();
    chk("rst_mid_tree_val", 64'(o_tree_val), 64'd0);
    chk("rst_mid_req_rdy", 64'(o_req_rdy), 64'd0);
    req_q[2].delete();
    push_beat(0, pack4(16'h70, 0, 0, 0), 8'h70, 1'b1, 1'b1, 0);
    push_beat(2, pack4(16'h72, 0, 0, 0), 8'h72, 1'b1, 1'b1, 0);
    step();
    k2 = cyc;
    rst = 1'b0;
    exp_beat(0, pack4(16'h70, 0, 0, 0), 8'h70, 1'b1, 1'b1, k2 + 1);
    exp_beat(2, pack4(16'h72, 0, 0, 0), 8'h72, 1'b1, 1'b1, k2 + 3);
    wait_drain("rst_mid", 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
